reg_spi_master: RTL

//  Host-side SPI master for the register command bus that the synth core decodes on S_SCK/S_MOSI/S_MISO/S_CS.

---
 rtl/reg_spi_master_if.sv | 35 +++
 rtl/reg_spi_master.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/reg_spi_master_if.sv
// Command/response port of the register SPI master.
// The "master" modport is the host that issues register commands; the
// "slave" modport is the SPI master block that accepts and executes them.
interface reg_spi_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [4:0]  cmd_addr;
   logic [15:0] cmd_data;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic        busy;

   modport master (
      output cmd_valid,
      output cmd_write,
      output cmd_addr,
      output cmd_data,
      input  cmd_ready,
      input  rsp_valid,
      input  rsp_data,
      input  busy
   );

   modport slave (
      input  cmd_valid,
      input  cmd_write,
      input  cmd_addr,
      input  cmd_data,
      output cmd_ready,
      output rsp_valid,
      output rsp_data,
      output busy
   );
endinterface

// File: rtl/reg_spi_master.sv
// Host-side SPI master (mode 0) for the synth register command bus.
// Each command becomes one 32-bit frame (write) or two frames (read):
//   write : {1'b1, 4'b0, addr, 6'b0, data}
//   read  : {1'b0, 4'b0, addr, 22'b0} sent twice; the second frame's MISO
//           bits carry the register value back (low 16 bits of the frame).
// S_MOSI is taken straight from the MSB of the tx shift register, so it only
// moves on the same clock edge that drops SCK or drops CS.
module reg_spi_master #(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   reg_spi_master_if.slave cmd_if,
   output logic            S_SCK,
   output logic            S_MOSI,
   input  logic            S_MISO,
   output logic            S_CS
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOW  = 3'd1;
   localparam logic [2:0] ST_HIGH = 3'd2;
   localparam logic [2:0] ST_HOLD = 3'd3;
   localparam logic [2:0] ST_GAP  = 3'd4;

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

   // Assemble the 32-bit bus frame for a command.
   function automatic logic [31:0] build_frame(input logic        write,
                                               input logic [4:0]  addr,
                                               input logic [15:0] data);
      logic [31:0] frame;
      if (write) begin
         frame = {1'b1, 4'b0000, addr, 6'b000000, data};
      end else begin
         frame = {1'b0, 4'b0000, addr, 22'h000000};
      end
      return frame;
   endfunction

   logic [2:0]  r_state;
   logic [15:0] r_div;
   logic [4:0]  r_bitcnt;
   logic [31:0] r_tx;
   logic [15:0] r_rx;
   logic [4:0]  r_addr;
   logic        r_read;
   logic        r_frame_b;
   logic        r_sck;
   logic        r_cs;
   logic        r_rsp_valid;
   logic [15:0] r_rsp_data;

   logic        w_idle;
   logic        w_accept;
   logic        w_div_last;
   logic        w_gap_last;
   logic        w_last_bit;
   logic [31:0] w_frame_cmd;
   logic [31:0] w_frame_b;

   assign w_idle      = (r_state == ST_IDLE);
   assign w_accept    = w_idle & cmd_if.cmd_valid;
   assign w_div_last  = (r_div == DIV_LAST);
   assign w_gap_last  = (r_div == GAP_LAST);
   assign w_last_bit  = (r_bitcnt == 5'd31);
   assign w_frame_cmd = build_frame(cmd_if.cmd_write, cmd_if.cmd_addr, cmd_if.cmd_data);
   assign w_frame_b   = build_frame(1'b0, r_addr, 16'h0000);

   assign S_SCK  = r_sck;
   assign S_CS   = r_cs;
   assign S_MOSI = r_tx[31];

   assign cmd_if.cmd_ready = w_idle;
   assign cmd_if.busy      = ~w_idle;
   assign cmd_if.rsp_valid = r_rsp_valid;
   assign cmd_if.rsp_data  = r_rsp_data;

   // Frame sequencer: SCK divider, bit shifting, CS framing and read response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_div       <= 16'h0000;
         r_bitcnt    <= 5'd0;
         r_tx        <= 32'h0000_0000;
         r_rx        <= 16'h0000;
         r_addr      <= 5'd0;
         r_read      <= 1'b0;
         r_frame_b   <= 1'b0;
         r_sck       <= 1'b0;
         r_cs        <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= 16'h0000;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_tx      <= w_frame_cmd;
                  r_addr    <= cmd_if.cmd_addr;
                  r_read    <= ~cmd_if.cmd_write;
                  r_frame_b <= 1'b0;
                  r_cs      <= 1'b0;
                  r_div     <= 16'h0000;
                  r_bitcnt  <= 5'd0;
                  r_state   <= ST_LOW;
               end
            end
            ST_LOW: begin
               if (w_div_last) begin
                  r_sck   <= 1'b1;
                  r_div   <= 16'h0000;
                  r_state <= ST_HIGH;
               end else begin
                  r_div <= r_div + 16'd1;
               end
            end
            ST_HIGH: begin
               if (w_div_last) begin
                  // Sample at the end of the high phase, then drop SCK.
                  r_rx  <= {r_rx[14:0], S_MISO};
                  r_sck <= 1'b0;
                  r_div <= 16'h0000;
                  if (w_last_bit) begin
                     r_state <= ST_HOLD;
                  end else begin
                     r_tx     <= {r_tx[30:0], 1'b0};
                     r_bitcnt <= r_bitcnt + 5'd1;
                     r_state  <= ST_LOW;
                  end
               end else begin
                  r_div <= r_div + 16'd1;
               end
            end
            ST_HOLD: begin
               if (w_div_last) begin
                  r_cs    <= 1'b1;
                  r_div   <= 16'h0000;
                  r_state <= ST_GAP;
                  // Only the second frame of a read carries the register value.
                  if (r_read && r_frame_b) begin
                     r_rsp_data  <= r_rx;
                     r_rsp_valid <= 1'b1;
                  end
               end else begin
                  r_div <= r_div + 16'd1;
               end
            end
            ST_GAP: begin
               if (w_gap_last) begin
                  r_div <= 16'h0000;
                  if (r_read && !r_frame_b) begin
                     // Read: go straight into frame B without releasing the port.
                     r_tx      <= w_frame_b;
                     r_frame_b <= 1'b1;
                     r_cs      <= 1'b0;
                     r_bitcnt  <= 5'd0;
                     r_state   <= ST_LOW;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_div <= r_div + 16'd1;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_div    <= 16'h0000;
               r_bitcnt <= 5'd0;
               r_sck    <= 1'b0;
               r_cs     <= 1'b1;
            end
         endcase
      end
   end

endmodule
